data_mem_arbiter: RTL
=====================

// Module: data_mem_arbiter
// PURPOSE
//  Round-robin arbiter that time-shares one single-port data RAM among the N processor cores.
//  Sits between the cores' memory interfaces (AR/DR/mem_write) and the data memory.
//  Serialises requests: at most one access is in flight at a time.
//  Returns read data and a one-cycle completion pulse to each core.
// PARAMETERS
//  reg_width   12  data word width (matches core DR/AR width)
//  addr_width  12  RAM address width; core addresses are truncated to the low addr_width bits
//  core_count  2   number of requesting cores (>=1)
// PORTS
//  clk        in   1                     system clock, all state on rising edge
//  reset      in   1                     asynchronous, active-low reset
//  req        in   core_count            per-core access request, level, held until ready
//  wr         in   core_count            per-core 1=write, 0=read; valid while req=1
//  addr_flat  in   core_count*reg_width  core i address at [i*reg_width +: reg_width]
//  wdata_flat in   core_count*reg_width  core i write data, same packing
//  ready      out  core_count            one-cycle completion pulse for core i
//  rdata_flat out  core_count*reg_width  core i read data, held until next read by core i
//  mem_addr   out  addr_width            RAM address (registered)
//  mem_wdata  out  reg_width             RAM write data (registered)
//  mem_wren   out  1                     RAM write enable (registered)
//  mem_rdata  in   reg_width             RAM output; registered RAM, valid 1 cycle after address
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, rr_ptr=0, ready=0, rdata_flat=0, mem_addr=0,
//   mem_wdata=0, mem_wren=0; any in-flight access is abandoned, no ready issued for it.
//  FSM states: IDLE -> ISSUE -> READ -> IDLE.
//  IDLE: eligible = req & ~ready. If eligible != 0, grant = first eligible index searching
//   rr_ptr, rr_ptr+1, ... wrapping mod core_count. On that edge latch grant, wr[grant],
//   addr[grant] (low addr_width bits) and wdata[grant] into mem_addr/mem_wdata/wren_q.
//   Go to ISSUE. If eligible == 0, stay in IDLE.
//  ISSUE: mem_wren = wren_q for exactly this cycle, 0 in every other state.
//   The RAM samples address/data at the edge ending ISSUE. Next state is READ.
//  READ: mem_rdata is valid. At the edge ending READ:
//   - if the access is a read, rdata slot[grant] <= mem_rdata; other slots are unchanged;
//     a write leaves all slots unchanged;
//   - ready[grant] <= 1 for one cycle; all other ready bits stay 0;
//   - rr_ptr <= (grant==core_count-1) ? 0 : grant+1;
//   - go to IDLE.
//  Latency: req seen at IDLE edge T0 -> ready high during cycle after edge T0+2.
//   Max throughput is one access per 3 cycles.
//  The ready cycle overlaps IDLE. The core whose ready=1 is excluded from arbitration that
//   cycle, which prevents double service while the core drops req.
//  Requester rules: hold req/wr/addr/wdata stable until ready; drop req or present a new
//   request the cycle after ready. If req drops mid-access, the latched access still
//   completes and ready still pulses.
//  Simultaneous requests: served in round-robin order starting at rr_ptr. No core waits
//   more than core_count accesses.
//  mem_addr/mem_wdata hold their last values outside ISSUE; only mem_wren gates writes.
// TESTING
//  1. Reset, then core0 read addr 0x005 with RAM[5]=0xABC -> mem_wren=0; ready[0] pulses
//     3 cycles after req; rdata slot0=0xABC; slot1=0.
//  2. Core1 write 0x123 to addr 0x010, then core1 read 0x010 -> mem_wren high exactly
//     1 cycle; read returns 0x123; slot0 unchanged.
//  3. Both cores request at the same edge after reset (rr_ptr=0) -> core0 served first,
//     core1 ready 3 cycles later. Repeat -> order 0,1 again (rr_ptr wrapped to 0).
//  4. Core1 holds req continuously while core0 requests once -> grants alternate 1,0,1;
//     ready is never asserted twice for a single request.
//  5. Assert reset during ISSUE of a write -> all outputs 0 immediately (async), mem_wren
//     drops, no ready; after release, a new request completes normally.
//  6. Core0 drops req during READ -> ready[0] still pulses once; no further grant to core0.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter time-sharing one registered single-port data RAM among core_count cores.
// One access in flight at a time: IDLE (grant) -> ISSUE (RAM samples) -> READ (data back) -> IDLE.
module data_mem_arbiter #(
    parameter int reg_width  = 12,
    parameter int addr_width = 12,
    parameter int core_count = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [core_count-1:0]           req,
    input  logic [core_count-1:0]           wr,
    input  logic [core_count*reg_width-1:0] addr_flat,
    input  logic [core_count*reg_width-1:0] wdata_flat,
    output logic [core_count-1:0]           ready,
    output logic [core_count*reg_width-1:0] rdata_flat,
    output logic [addr_width-1:0]           mem_addr,
    output logic [reg_width-1:0]            mem_wdata,
    output logic                            mem_wren,
    input  logic [reg_width-1:0]            mem_rdata
);

    localparam int IDX_W = (core_count > 1) ? $clog2(core_count) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        READ
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]       grant_q, grant_d;
    logic                   wren_q, wren_d;
    logic [addr_width-1:0]  mem_addr_q, mem_addr_d;
    logic [reg_width-1:0]   mem_wdata_q, mem_wdata_d;
    logic                   mem_wren_q, mem_wren_d;
    logic [core_count-1:0]  ready_q, ready_d;
    logic [reg_width-1:0]   rdata_q [core_count];
    logic [reg_width-1:0]   rdata_d [core_count];

    logic [core_count-1:0]  eligible;
    logic [IDX_W-1:0]       sel;
    logic                   found;
    logic [reg_width-1:0]   sel_addr;
    logic [reg_width-1:0]   sel_wdata;
    int                     idx;

    // A core whose ready is high this cycle is masked so it cannot be served twice.
    always_comb begin
        eligible = req & ~ready_q;
        sel      = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < core_count; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= core_count) begin
                idx = idx - core_count;
            end
            if (!found && eligible[idx]) begin
                found = 1'b1;
                sel   = IDX_W'(idx);
            end
        end
        sel_addr  = addr_flat[int'(sel)*reg_width +: reg_width];
        sel_wdata = wdata_flat[int'(sel)*reg_width +: reg_width];
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        wren_d      = wren_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wren_d  = 1'b0;
        ready_d     = '0;
        rdata_d     = rdata_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d     = sel;
                    wren_d      = wr[sel];
                    mem_addr_d  = addr_width'(sel_addr);
                    mem_wdata_d = sel_wdata;
                    mem_wren_d  = wr[sel];
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                state_d = READ;
            end
            READ: begin
                if (!wren_q) begin
                    rdata_d[grant_q] = mem_rdata;
                end
                ready_d[grant_q] = 1'b1;
                rr_ptr_d = (grant_q == IDX_W'(core_count - 1)) ? '0 : grant_q + 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            wren_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wren_q  <= 1'b0;
            ready_q     <= '0;
            for (int i = 0; i < core_count; i++) begin
                rdata_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            wren_q      <= wren_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wren_q  <= mem_wren_d;
            ready_q     <= ready_d;
            rdata_q     <= rdata_d;
        end
    end

    always_comb begin
        for (int i = 0; i < core_count; i++) begin
            rdata_flat[i*reg_width +: reg_width] = rdata_q[i];
        end
    end

    assign ready     = ready_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wren  = mem_wren_q;

endmodule
